// File: rtl/usrt_tx.sv
// USRT transmitter: one-entry holding register feeding an LSB-first start/data/[parity]/stop serialiser.
// Optional even-parity bit compiled in when USRT_TX_PARITY_EN is defined; bits advance on i_BitEn strobes.
module usrt_tx #(
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1
) (
   input  logic              i_Pclk,
   input  logic              i_Reset,
   input  logic              i_Write,
   input  logic [DATA_W-1:0] i_Data,
   input  logic              i_BitEn,
   output logic              o_TxD,
   output logic              o_Empty,
   output logic              o_Busy,
   output logic              o_Done,
   output logic              o_Overrun
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd4;
`ifdef USRT_TX_PARITY_EN
   localparam logic [2:0] S_PAR   = 3'd3;
`endif

   logic [2:0]        state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              full_q, full_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [2:0]        bitcnt_q, bitcnt_d;
   logic              stopcnt_q, stopcnt_d;
   logic              txd_q, txd_d;
   logic              done_q, done_d;
   logic              ovr_q, ovr_d;
`ifdef USRT_TX_PARITY_EN
   logic              par_q, par_d;
`endif
   logic              xfer;

   // The holding register empties in the same cycle IDLE copies it, so a write then is still accepted.
   assign xfer = (state_q == S_IDLE) && full_q;

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      full_d    = full_q;
      shift_d   = shift_q;
      bitcnt_d  = bitcnt_q;
      stopcnt_d = stopcnt_q;
      txd_d     = txd_q;
      done_d    = 1'b0;
      ovr_d     = 1'b0;
`ifdef USRT_TX_PARITY_EN
      par_d     = par_q;
`endif

      if (i_Write) begin
         if (!full_q || xfer) begin
            hold_d = i_Data;
            full_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (xfer) begin
         full_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (full_q) begin
               shift_d = hold_q;
`ifdef USRT_TX_PARITY_EN
               par_d   = ^hold_q;
`endif
               state_d = S_START;
            end
         end
         S_START: begin
            if (i_BitEn) begin
               txd_d    = 1'b0;
               bitcnt_d = 3'd0;
               state_d  = S_DATA;
            end
         end
         S_DATA: begin
            if (i_BitEn) begin
               txd_d   = shift_q[0];
               shift_d = shift_q >> 1;
               if (bitcnt_q == 3'(DATA_W - 1)) begin
                  stopcnt_d = 1'b0;
`ifdef USRT_TX_PARITY_EN
                  state_d   = S_PAR;
`else
                  state_d   = S_STOP;
`endif
               end else begin
                  bitcnt_d = bitcnt_q + 3'd1;
               end
            end
         end
`ifdef USRT_TX_PARITY_EN
         S_PAR: begin
            if (i_BitEn) begin
               txd_d   = par_q;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (i_BitEn) begin
               txd_d = 1'b1;
               if (stopcnt_q == 1'(STOP_BITS - 1)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  stopcnt_d = stopcnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         state_q   <= S_IDLE;
         hold_q    <= '0;
         full_q    <= 1'b0;
         shift_q   <= '0;
         bitcnt_q  <= 3'd0;
         stopcnt_q <= 1'b0;
         txd_q     <= 1'b1;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef USRT_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         full_q    <= full_d;
         shift_q   <= shift_d;
         bitcnt_q  <= bitcnt_d;
         stopcnt_q <= stopcnt_d;
         txd_q     <= txd_d;
         done_q    <= done_d;
         ovr_q     <= ovr_d;
`ifdef USRT_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign o_TxD     = txd_q;
   assign o_Empty   = !full_q;
   assign o_Busy    = (state_q != S_IDLE);
   assign o_Done    = done_q;
   assign o_Overrun = ovr_q;

endmodule

// File: tb/tb_usrt_tx.sv
// Scoreboarded bench for usrt_tx: accepted bytes are queued and matched against frames decoded from o_TxD.
module tb_usrt_tx;
   localparam int DW = 8;
   localparam int SB = 1;
`ifdef USRT_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FLEN = 1 + DW + PB + SB;

   logic          i_Pclk = 1'b0;
   logic          i_Reset = 1'b1;
   logic          i_Write = 1'b0;
   logic [DW-1:0] i_Data = '0;
   logic          i_BitEn = 1'b0;
   logic          o_TxD, o_Empty, o_Busy, o_Done, o_Overrun;

   usrt_tx #(.DATA_W(DW), .STOP_BITS(SB)) dut (
      .i_Pclk(i_Pclk), .i_Reset(i_Reset), .i_Write(i_Write), .i_Data(i_Data),
      .i_BitEn(i_BitEn), .o_TxD(o_TxD), .o_Empty(o_Empty), .o_Busy(o_Busy),
      .o_Done(o_Done), .o_Overrun(o_Overrun));

   always #5 i_Pclk = ~i_Pclk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
      end
   endtask

   // Reference model: holding flag plus count of bit periods left in the current frame.
   logic [DW-1:0] exp_q[$];
   bit  m_full = 0, m_xfer = 0, exp_ovr = 0, exp_done = 0;
   bit  rst_seen = 0, strobe_seen = 0, started = 0;
   int  m_rem = 0;

   always @(posedge i_Pclk) begin
      started     = 1;
      rst_seen    = i_Reset;
      strobe_seen = 0;
      exp_ovr     = 0;
      exp_done    = 0;
      if (i_Reset) begin
         m_full = 0;
         m_rem  = 0;
         exp_q.delete();
      end else begin
         m_xfer = (m_rem == 0) && m_full;
         if (i_Write) begin
            if (!m_full || m_xfer) begin
               exp_q.push_back(i_Data);
               m_full = 1;
            end else begin
               exp_ovr = 1;
            end
         end else if (m_xfer) begin
            m_full = 0;
         end
         if (m_xfer) m_rem = FLEN;
         else if (m_rem > 0 && i_BitEn) begin
            m_rem--;
            if (m_rem == 0) exp_done = 1;
         end
         strobe_seen = i_BitEn;
      end
   end

   // Monitor: per-cycle flag checks and a serial frame decoder on o_TxD.
   bit            dec_active = 0;
   int            dec_idx = 0;
   logic [DW-1:0] dec_byte = '0;
   logic          dec_par = 1'b0;
   logic          last_txd = 1'b1;
   logic [DW-1:0] want;

   always @(negedge i_Pclk) begin
      if (started) begin
         chk("empty", o_Empty, !m_full);
         chk("busy", o_Busy, m_rem != 0);
         chk("done", o_Done, exp_done);
         chk("overrun", o_Overrun, exp_ovr);
         if (rst_seen) begin
            chk("txd_reset", o_TxD, 1'b1);
            dec_active = 0;
         end else if (strobe_seen) begin
            if (!dec_active) begin
               if (o_TxD == 1'b0) begin
                  dec_active = 1;
                  dec_idx    = 0;
                  dec_byte   = '0;
               end
            end else begin
               if (dec_idx < DW) dec_byte[dec_idx] = o_TxD;
               else if (dec_idx < DW + PB) dec_par = o_TxD;
               else chk("stop_bit", o_TxD, 1'b1);
               dec_idx++;
               if (dec_idx == DW + PB + SB) begin
                  dec_active = 0;
                  if (exp_q.size() == 0) begin
                     chk("frame_unexpected", dec_byte, 32'hFFFF_FFFF);
                  end else begin
                     want = exp_q.pop_front();
                     chk("frame_data", dec_byte, want);
                     if (PB != 0) chk("parity", dec_par, ^want);
                  end
               end
            end
         end else begin
            chk("txd_hold", o_TxD, last_txd);
         end
         last_txd = o_TxD;
      end
   end

   // Bit-strobe generator: 0 = every 4 cycles, 1 = random, 2 = every cycle.
   int be_mode = 1;
   int be_cnt  = 0;
   initial forever begin
      @(posedge i_Pclk); #1;
      be_cnt = (be_cnt + 1) % 4;
      case (be_mode)
         0:       i_BitEn = (be_cnt == 0);
         1:       i_BitEn = ($urandom_range(0, 2) == 0);
         default: i_BitEn = 1'b1;
      endcase
   end

   task automatic tick();
      @(posedge i_Pclk); #1;
   endtask

   task automatic wr(input logic [DW-1:0] b);
      i_Write = 1'b1;
      i_Data  = b;
      tick();
      i_Write = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((m_rem != 0 || m_full || dec_active) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) chk("idle_timeout", 1, 0);
      repeat (3) tick();
   endtask

   initial begin
      tick();
      repeat (8) begin
         i_Write = 1'($urandom_range(0, 1));
         i_Data  = DW'($urandom);
         tick();
      end
      i_Write = 1'b0;
      i_Reset = 1'b0;
      be_mode = 0;
      repeat (4) tick();

      wr(8'hA5);
      wait_idle(400);

      wr(8'h55);
      repeat (16) tick();
      wr(8'h0F);
      wait_idle(400);

      wr(8'h11);
      repeat (8) tick();
      wr(8'h22);
      repeat (4) tick();
      wr(8'h33);
      wait_idle(600);

      wr(8'hF0);
      repeat (22) tick();
      wr(8'h99);
      i_Reset = 1'b1;
      tick();
      tick();
      i_Reset = 1'b0;
      repeat (80) tick();
      chk("no_frame_after_reset", {31'd0, dec_active}, 0);

      be_mode = 1;
      repeat (3000) begin
         i_Write = ($urandom_range(0, 5) == 0);
         i_Data  = DW'($urandom);
         tick();
      end
      be_mode = 2;
      repeat (500) begin
         i_Write = ($urandom_range(0, 3) == 0);
         i_Data  = DW'($urandom);
         tick();
      end
      i_Write = 1'b0;
      wait_idle(2000);
      chk("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
